id_ex_pipe_stage: RTL and testbench

//  Parametrised ID->EX pipeline stage register with valid/ready handshake, flush and optional skid buffer.

---
 rtl/id_ex_pipe_stage.sv | 110 +++++++++++
 tb/tb_id_ex_pipe_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline stage register: valid/ready handshake, synchronous flush and an optional skid entry.
// Control, operands and register addresses travel as one packed beat so every field moves together.
module id_ex_pipe_stage #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NDATA  = 3,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NADDR  = 3,
  parameter int unsigned SKID   = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [CTRL_W-1:0]         ctrl_i,
  input  logic [NDATA*DATA_W-1:0]   data_i,
  input  logic [NADDR*ADDR_W-1:0]   addr_i,
  input  logic                      flush_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [CTRL_W-1:0]         ctrl_o,
  output logic [NDATA*DATA_W-1:0]   data_o,
  output logic [NADDR*ADDR_W-1:0]   addr_o,
  output logic [1:0]                count_o
);

  localparam int unsigned PAY_W  = NDATA*DATA_W + NADDR*ADDR_W;
  localparam int unsigned BEAT_W = CTRL_W + PAY_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e              state_q, state_d;
  logic [BEAT_W-1:0] main_q, main_d;
  logic [BEAT_W-1:0] skid_q, skid_d;
  logic [BEAT_W-1:0] beat_in;
  logic              main_valid, skid_valid;
  logic              accept, rel;

  assign beat_in    = {ctrl_i, data_i, addr_i};
  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  // With the skid entry, ready depends only on state, breaking the ready_i -> ready_o path.
  if (SKID != 0) begin : g_skid
    assign ready_o = ~skid_valid;
  end else begin : g_noskid
    assign ready_o = ~main_valid | ready_i;
  end

  assign accept = valid_i & ready_o & ~flush_i;
  assign rel    = main_valid & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = beat_in;
          end
        end
        ONE: begin
          if (accept && rel) begin
            main_d = beat_in;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = beat_in;
          end else if (rel) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (rel) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign valid_o = main_valid;
  assign ctrl_o  = main_valid ? main_q[BEAT_W-1 -: CTRL_W] : '0;
  assign data_o  = main_q[NADDR*ADDR_W +: NDATA*DATA_W];
  assign addr_o  = main_q[NADDR*ADDR_W-1:0];
  assign count_o = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: a SKID=1 and a SKID=0 instance, each checked against its own FIFO scoreboard.
`timescale 1ns/1ps
module tb_id_ex_pipe_stage;

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned ND = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned NA = 3;
  localparam int unsigned PW = ND*DW + NA*AW;
  localparam int unsigned BW = CW + PW;
  localparam int unsigned OW = 1 + BW + 2 + 1;

  logic clk = 1'b0;
  logic rst, valid1_i, valid0_i, ready_i, flush_i;
  logic [CW-1:0]    ctrl_i;
  logic [ND*DW-1:0] data_i;
  logic [NA*AW-1:0] addr_i;

  logic rdy1, v1, rdy0, v0;
  logic [CW-1:0]    c1, c0;
  logic [ND*DW-1:0] d1, d0;
  logic [NA*AW-1:0] a1, a0;
  logic [1:0]       cnt1, cnt0;

  always #5 clk = ~clk;

  id_ex_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .NDATA(ND), .ADDR_W(AW), .NADDR(NA), .SKID(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid1_i), .ready_o(rdy1),
    .ctrl_i(ctrl_i), .data_i(data_i), .addr_i(addr_i), .flush_i(flush_i),
    .valid_o(v1), .ready_i(ready_i), .ctrl_o(c1), .data_o(d1), .addr_o(a1), .count_o(cnt1)
  );

  id_ex_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .NDATA(ND), .ADDR_W(AW), .NADDR(NA), .SKID(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid0_i), .ready_o(rdy0),
    .ctrl_i(ctrl_i), .data_i(data_i), .addr_i(addr_i), .flush_i(flush_i),
    .valid_o(v0), .ready_i(ready_i), .ctrl_o(c0), .data_o(d0), .addr_o(a0), .count_o(cnt0)
  );

  int checks = 0;
  int fails  = 0;

  logic [BW-1:0] q1[$];
  logic [BW-1:0] q0[$];
  logic          acc1, acc0;
  logic [OW-1:0] exp1, exp0, obs1, obs0;

  // Payload is don't-care while invalid, so it is masked out of the observation.
  assign obs1 = {v1, c1, v1 ? {d1, a1} : {PW{1'b0}}, cnt1, rdy1};
  assign obs0 = {v0, c0, v0 ? {d0, a0} : {PW{1'b0}}, cnt0, rdy0};

  function automatic logic [OW-1:0] expect_of(input logic [BW-1:0] head, input int unsigned n, input logic rdy);
    if (n == 0) return {1'b0, {BW{1'b0}}, 2'd0, rdy};
    return {1'b1, head, 2'(n), rdy};
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic r1, r0;
    logic [BW-1:0] h1, h0;
    acc1 = 1'b0;
    acc0 = 1'b0;
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      r1 = (q1.size() < 2);
      if (q1.size() != 0 && ready_i) void'(q1.pop_front());
      if (flush_i) q1.delete();
      else if (valid1_i && r1) begin q1.push_back({ctrl_i, data_i, addr_i}); acc1 = 1'b1; end
      r0 = (q0.size() == 0) || ready_i;
      if (q0.size() != 0 && ready_i) void'(q0.pop_front());
      if (flush_i) q0.delete();
      else if (valid0_i && r0) begin q0.push_back({ctrl_i, data_i, addr_i}); acc0 = 1'b1; end
    end
    h1 = '0;
    h0 = '0;
    if (q1.size() != 0) h1 = q1[0];
    if (q0.size() != 0) h0 = q0[0];
    exp1 = expect_of(h1, q1.size(), q1.size() < 2);
    exp0 = expect_of(h0, q0.size(), (q0.size() == 0) || ready_i);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic pv1, input logic pv0, input logic [7:0] c, input logic [31:0] w0);
    valid1_i = pv1;
    valid0_i = pv0;
    ctrl_i   = c;
    data_i   = {w0 ^ 32'h5A5A_0000, ~w0, w0};
    addr_i   = {w0[4:0] + 5'd2, w0[4:0] + 5'd1, w0[4:0]};
  endtask

  task automatic test_reset();
    rst = 1'b1; ready_i = 1'b0; flush_i = 1'b0;
    put(1'b0, 1'b0, 8'h00, 32'h0);
    tick(); tick();
    checks++; if ({v1, c1, cnt1, rdy1} !== {1'b0, 8'h00, 2'd0, 1'b1}) begin fails++;
      $display("FAIL reset_skid1 got=%h exp=%h", {v1, c1, cnt1, rdy1}, {1'b0, 8'h00, 2'd0, 1'b1}); end
    checks++; if ({v0, c0, cnt0, rdy0} !== {1'b0, 8'h00, 2'd0, 1'b1}) begin fails++;
      $display("FAIL reset_skid0 got=%h exp=%h", {v0, c0, cnt0, rdy0}, {1'b0, 8'h00, 2'd0, 1'b1}); end
    rst = 1'b0;
    put(1'b1, 1'b0, 8'h11, 32'h1); tick();
    checks++; if (obs1 !== exp1) begin fails++; $display("FAIL fill1 got=%h exp=%h", obs1, exp1); end
    put(1'b1, 1'b0, 8'h12, 32'h2); tick();
    checks++; if (obs1 !== exp1) begin fails++; $display("FAIL fill2 got=%h exp=%h", obs1, exp1); end
    checks++; if ({cnt1, rdy1} !== {2'd2, 1'b0}) begin fails++;
      $display("FAIL full_state got=%h exp=%h", {cnt1, rdy1}, {2'd2, 1'b0}); end
    put(1'b0, 1'b0, 8'h00, 32'h0);
    #3 rst = 1'b1;
    #1;
    checks++; if ({v1, c1, cnt1, rdy1} !== {1'b0, 8'h00, 2'd0, 1'b1}) begin fails++;
      $display("FAIL reset_midfull got=%h exp=%h", {v1, c1, cnt1, rdy1}, {1'b0, 8'h00, 2'd0, 1'b1}); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (obs1 !== exp1) begin fails++; $display("FAIL post_reset got=%h exp=%h", obs1, exp1); end
  endtask

  task automatic test_stream();
    ready_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      put(1'b1, 1'b1, 8'(i), 32'(i * 16));
      tick();
      checks++; if (obs1 !== exp1) begin fails++; $display("FAIL stream_skid1 got=%h exp=%h", obs1, exp1); end
      checks++; if (obs0 !== exp0) begin fails++; $display("FAIL stream_skid0 got=%h exp=%h", obs0, exp0); end
      checks++; if ({v1, c1, cnt1, rdy1} !== {1'b1, 8'(i), 2'd1, 1'b1}) begin fails++;
        $display("FAIL stream_seq got=%h exp=%h", {v1, c1, cnt1, rdy1}, {1'b1, 8'(i), 2'd1, 1'b1}); end
    end
    put(1'b0, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (obs1 !== exp1) begin fails++; $display("FAIL stream_tail1 got=%h exp=%h", obs1, exp1); end
      checks++; if (obs0 !== exp0) begin fails++; $display("FAIL stream_tail0 got=%h exp=%h", obs0, exp0); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] seen[$];
    ready_i = 1'b0;
    put(1'b1, 1'b0, 8'h21, 32'hA); tick();
    checks++; if (obs1 !== exp1) begin fails++; $display("FAIL bp_a got=%h exp=%h", obs1, exp1); end
    put(1'b1, 1'b0, 8'h22, 32'hB); tick();
    checks++; if (obs1 !== exp1) begin fails++; $display("FAIL bp_b got=%h exp=%h", obs1, exp1); end
    put(1'b1, 1'b0, 8'h23, 32'hC);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (obs1 !== exp1) begin fails++; $display("FAIL bp_c got=%h exp=%h", obs1, exp1); end
      checks++; if ({v1, c1, d1[31:0], cnt1, rdy1} !== {1'b1, 8'h21, 32'hA, 2'd2, 1'b0}) begin fails++;
        $display("FAIL bp_hold got=%h exp=%h", {v1, c1, d1[31:0], cnt1, rdy1}, {1'b1, 8'h21, 32'hA, 2'd2, 1'b0}); end
    end
    ready_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (v1) seen.push_back(c1);
      tick();
      checks++; if (obs1 !== exp1) begin fails++; $display("FAIL bp_drain got=%h exp=%h", obs1, exp1); end
      if (acc1) valid1_i = 1'b0;
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 8'h21 || seen[1] !== 8'h22 || seen[2] !== 8'h23) begin
      fails++; $display("FAIL bp_order got=%0d beats exp=3 (21,22,23)", seen.size());
    end
  endtask

  task automatic test_flush();
    ready_i = 1'b0;
    put(1'b1, 1'b1, 8'h31, 32'h31); tick();
    checks++; if (obs1 !== exp1) begin fails++; $display("FAIL fl_fill1 got=%h exp=%h", obs1, exp1); end
    put(1'b1, 1'b0, 8'h32, 32'h32); tick();
    checks++; if (obs1 !== exp1) begin fails++; $display("FAIL fl_fill2 got=%h exp=%h", obs1, exp1); end
    put(1'b1, 1'b1, 8'h3D, 32'hD);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    put(1'b0, 1'b0, 8'h00, 32'h0);
    checks++; if ({v1, c1, cnt1} !== {1'b0, 8'h00, 2'd0}) begin fails++;
      $display("FAIL flush_skid1 got=%h exp=%h", {v1, c1, cnt1}, {1'b0, 8'h00, 2'd0}); end
    checks++; if ({v0, c0, cnt0} !== {1'b0, 8'h00, 2'd0}) begin fails++;
      $display("FAIL flush_skid0 got=%h exp=%h", {v0, c0, cnt0}, {1'b0, 8'h00, 2'd0}); end
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (obs1 !== exp1) begin fails++; $display("FAIL flush_after1 got=%h exp=%h", obs1, exp1); end
      checks++; if (obs0 !== exp0) begin fails++; $display("FAIL flush_after0 got=%h exp=%h", obs0, exp0); end
    end
  endtask

  task automatic test_bubble();
    ready_i = 1'b1;
    put(1'b1, 1'b1, 8'hFF, 32'hF0F0); tick();
    checks++; if ({v1, c1, v0, c0} !== {1'b1, 8'hFF, 1'b1, 8'hFF}) begin fails++;
      $display("FAIL bubble_beat got=%h exp=%h", {v1, c1, v0, c0}, {1'b1, 8'hFF, 1'b1, 8'hFF}); end
    put(1'b0, 1'b0, 8'hFF, 32'hF0F0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({c1, c0} !== 16'h0000) begin fails++;
        $display("FAIL bubble_ctrl got=%h exp=%h", {c1, c0}, 16'h0000); end
      checks++; if (obs1 !== exp1) begin fails++; $display("FAIL bubble_obs1 got=%h exp=%h", obs1, exp1); end
    end
  endtask

  task automatic test_skid0();
    ready_i = 1'b0;
    put(1'b0, 1'b1, 8'h41, 32'h41); tick();
    checks++; if (obs0 !== exp0) begin fails++; $display("FAIL s0_load got=%h exp=%h", obs0, exp0); end
    put(1'b0, 1'b1, 8'h42, 32'h42); tick();
    checks++; if (obs0 !== exp0) begin fails++; $display("FAIL s0_hold got=%h exp=%h", obs0, exp0); end
    checks++; if ({rdy0, v0, c0} !== {1'b0, 1'b1, 8'h41}) begin fails++;
      $display("FAIL s0_notready got=%h exp=%h", {rdy0, v0, c0}, {1'b0, 1'b1, 8'h41}); end
    ready_i = 1'b1;
    #1;
    checks++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL s0_ready_comb got=%b exp=1", rdy0); end
    tick();
    if (acc0) valid0_i = 1'b0;
    checks++; if (obs0 !== exp0) begin fails++; $display("FAIL s0_replace got=%h exp=%h", obs0, exp0); end
    checks++; if ({v0, c0, cnt0} !== {1'b1, 8'h42, 2'd1}) begin fails++;
      $display("FAIL s0_nogap got=%h exp=%h", {v0, c0, cnt0}, {1'b1, 8'h42, 2'd1}); end
    put(1'b0, 1'b0, 8'h00, 32'h0); tick();
    checks++; if (obs0 !== exp0) begin fails++; $display("FAIL s0_drain got=%h exp=%h", obs0, exp0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_skid0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
